// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory controller:
// access-size and FSM state enums, the access-error check and the load
// lane-extract / sign-or-zero extension function.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  // Illegal size or a lane offset that does not match the access size.
  function automatic logic access_err(input size_e size, input logic [1:0] lane);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = lane[0];
      SZ_W:    err = |lane;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Right-justify the addressed lanes of a memory word, then extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input size_e       size,
                                              input logic        uns);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext_b;
    logic signed [31:0] ext_h;
    logic        [31:0] res;
    sh    = word >> {lane, 3'b000};
    b     = sh[7:0];
    h     = sh[15:0];
    ext_b = b;
    ext_h = h;
    case (size)
      SZ_B:    res = uns ? {24'h0, sh[7:0]}  : ext_b;
      SZ_H:    res = uns ? {16'h0, sh[15:0]} : ext_h;
      SZ_W:    res = sh;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus of the data memory: valid/ready request channel and
// a single-cycle response pulse with load data and error flag.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32-bit storage with a per-byte write enable and a synchronous
// read port; the read register holds its value until the next read.
module dmem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [3:0]               i_be,
  input  logic [31:0]              i_wdata,
  input  logic                     i_re,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata_p0;

  // Byte-lane writes and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata_p0 <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata_p0;

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: accepts one byte/half/word request at a time,
// writes stores at the accept edge, returns extended load data after
// RD_LAT cycles and flags misaligned, illegal-size or out-of-range accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIM = 33'(DEPTH) * 33'd4;
  localparam logic [1:0]  CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;

  logic        w_accept;
  size_e       w_size;
  logic [1:0]  w_lane;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [3:0]  w_be_gated;
  logic        w_re;
  logic [31:0] w_rdata;

  // Request attributes captured at accept, aligned with the array read data.
  logic [1:0]  r_lane_p0;
  size_e       r_size_p0;
  logic        r_uns_p0;
  logic        r_err_p0;
  logic        r_we_p0;

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_size   = size_e'(bus.req_size);
  assign w_lane   = bus.req_addr[1:0];
  assign w_err    = access_err(w_size, w_lane) || ({1'b0, bus.req_addr} >= ADDR_LIM);

  // Replicate store data across lanes and select the addressed byte enables.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.req_wdata;
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      SZ_H: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      SZ_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_be_gated = (w_accept && bus.req_we && !w_err) ? w_be : 4'b0000;
  assign w_re       = w_accept && !bus.req_we && !w_err;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .i_addr  (bus.req_addr[AW+1:2]),
    .i_be    (w_be_gated),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .o_rdata (w_rdata)
  );

  // FSM state and latency counter; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: stores, errors and single-cycle loads respond directly.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.req_we || w_err || RD_LAT == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 2'd0) w_state_nxt = RESP;
        else               w_cnt_nxt   = r_cnt - 2'd1;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0: latch request attributes at the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lane_p0 <= w_lane;
      r_size_p0 <= w_size;
      r_uns_p0  <= bus.req_unsigned;
      r_err_p0  <= w_err;
      r_we_p0   <= bus.req_we;
    end
  end

  // Outputs derive only from registers, so they move on clock edges and
  // stay zero outside the RESP cycle.
  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_err   = (r_state == RESP) && r_err_p0;
  assign bus.rsp_rdata = ((r_state == RESP) && !r_err_p0 && !r_we_p0)
                         ? load_extend(w_rdata, r_lane_p0, r_size_p0, r_uns_p0)
                         : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: four instances (RD_LAT = 1..4) share one request
// stream; a byte-array reference model predicts every response.
module tb_dmem_ctrl;

  localparam int DEPTH = 64;
  localparam int NB    = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        t_valid;
  logic        t_we;
  logic [31:0] t_addr;
  logic [1:0]  t_size;
  logic        t_uns;
  logic [31:0] t_wdata;

  logic        u_ready [4];
  logic        u_valid [4];
  logic        u_err   [4];
  logic [31:0] u_rdata [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_if u_if ();
    dmem_ctrl #(.DEPTH(DEPTH), .RD_LAT(g + 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
    );
    assign u_if.req_valid    = t_valid;
    assign u_if.req_we       = t_we;
    assign u_if.req_addr     = t_addr;
    assign u_if.req_size     = t_size;
    assign u_if.req_unsigned = t_uns;
    assign u_if.req_wdata    = t_wdata;
    assign u_ready[g] = u_if.req_ready;
    assign u_valid[g] = u_if.rsp_valid;
    assign u_err[g]   = u_if.rsp_err;
    assign u_rdata[g] = u_if.rsp_rdata;
  end

  logic [3:0] rdy_v;
  logic [3:0] vld_v;
  logic [3:0] busy_out_v;
  always_comb begin
    rdy_v      = 4'h0;
    vld_v      = 4'h0;
    busy_out_v = 4'h0;
    for (int g = 0; g < 4; g++) begin
      rdy_v[g]      = u_ready[g];
      vld_v[g]      = u_valid[g];
      busy_out_v[g] = u_err[g] || (u_rdata[g] != 32'h0);
    end
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Reference model: flat byte memory and the access rules in plain arithmetic.
  logic [7:0] mdl [NB];

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0) || (a >= NB);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    longint v;
    int     n;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(mdl[a + i]) << (8 * i);
    if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) mdl[a + i] = 8'(wd >> (8 * i));
  endtask

  logic [31:0] obs_rdata [4];
  logic        obs_err   [4];

  // One request to all instances; checks every cycle until all have drained.
  task automatic do_txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
    bit          e;
    logic [31:0] exp_d;
    int          lat [4];
    logic [3:0]  exp_v;
    logic [3:0]  exp_r;
    e     = ref_err(a, sz);
    exp_d = (we || e) ? 32'h0 : ref_load(a, sz, uns);
    for (int g = 0; g < 4; g++) lat[g] = (we || e) ? 1 : g + 1;
    @(negedge clk);
    t_valid = 1'b1; t_we = we; t_addr = a; t_size = sz; t_uns = uns; t_wdata = wd;
    chk("ready_before_accept", {28'h0, rdy_v}, 32'hF);
    @(posedge clk);
    if (we && !e) ref_store(a, sz, wd);
    #1;
    t_valid = 1'b0; t_addr = $urandom; t_wdata = $urandom;
    t_size = 2'($urandom); t_we = 1'($urandom); t_uns = 1'($urandom);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = 4'h0;
      exp_r = 4'h0;
      for (int g = 0; g < 4; g++) begin
        if (k == lat[g]) exp_v[g] = 1'b1;
        if (k >  lat[g]) exp_r[g] = 1'b1;
      end
      chk($sformatf("rsp_valid@%0d a=%h", k, a), {28'h0, vld_v}, {28'h0, exp_v});
      chk($sformatf("req_ready@%0d a=%h", k, a), {28'h0, rdy_v}, {28'h0, exp_r});
      chk($sformatf("idle_outputs_zero@%0d", k), {28'h0, busy_out_v & ~exp_v}, 32'h0);
      for (int g = 0; g < 4; g++) begin
        if (exp_v[g]) begin
          obs_rdata[g] = u_rdata[g];
          obs_err[g]   = u_err[g];
          chk($sformatf("rdata L%0d a=%h sz=%0d we=%0d", g + 1, a, sz, we), u_rdata[g], exp_d);
          chk($sformatf("err L%0d a=%h sz=%0d", g + 1, a, sz), {31'h0, u_err[g]}, {31'h0, e});
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int acc [4];
    int r;
    logic [31:0] a;
    logic [1:0]  sz;

    rst_n = 1'b0;
    t_valid = 1'b0; t_we = 1'b0; t_addr = '0; t_size = '0; t_uns = 1'b0; t_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {28'h0, rdy_v}, 32'hF);
    chk("reset_valid", {28'h0, vld_v}, 32'h0);
    chk("reset_outputs", {28'h0, busy_out_v}, 32'h0);

    // Preset every word so no load touches uninitialised storage.
    for (int w = 0; w < DEPTH; w++) do_txn(1'b1, 32'(4 * w), 2'd2, 1'b0, 32'h0);

    // Word round-trip.
    do_txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    for (int g = 0; g < 4; g++) chk("roundtrip_word", obs_rdata[g], 32'hDEADBEEF);
    chk("roundtrip_err", {31'h0, obs_err[0]}, 32'h0);

    // Byte and half lanes with extension.
    do_txn(1'b1, 32'h21, 2'd0, 1'b0, 32'hFFFF_FF80);
    do_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    chk("byte_store_word", obs_rdata[0], 32'h0000_8000);
    do_txn(1'b0, 32'h21, 2'd0, 1'b0, 32'h0);
    chk("byte_load_signed", obs_rdata[1], 32'hFFFF_FF80);
    do_txn(1'b0, 32'h21, 2'd0, 1'b1, 32'h0);
    chk("byte_load_unsigned", obs_rdata[2], 32'h0000_0080);
    do_txn(1'b1, 32'h22, 2'd1, 1'b0, 32'hAAAA_1234);
    do_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    chk("half_store_word", obs_rdata[3], 32'h1234_8000);

    // Error cases.
    do_txn(1'b0, 32'h13, 2'd2, 1'b0, 32'h0);
    chk("misaligned_word_err", {31'h0, obs_err[0]}, 32'h1);
    chk("misaligned_word_rdata", obs_rdata[0], 32'h0);
    do_txn(1'b1, 32'h21, 2'd1, 1'b0, 32'h5555);
    chk("misaligned_half_store_err", {31'h0, obs_err[1]}, 32'h1);
    do_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    chk("word_after_bad_store", obs_rdata[0], 32'h1234_8000);
    do_txn(1'b0, 32'h20, 2'd3, 1'b0, 32'h0);
    chk("illegal_size_err", {31'h0, obs_err[2]}, 32'h1);
    do_txn(1'b0, 32'(NB), 2'd2, 1'b0, 32'h0);
    chk("out_of_range_err", {31'h0, obs_err[3]}, 32'h1);
    do_txn(1'b1, 32'(NB), 2'd0, 1'b0, 32'h77);
    chk("out_of_range_store_err", {31'h0, obs_err[0]}, 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = 32'($urandom_range(0, NB + 15));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~(32'(1 << sz) - 32'd1);
      do_txn(1'($urandom), a, sz, 1'($urandom), $urandom);
    end

    // Throughput with request held valid: one accept per RD_LAT+1 cycles.
    for (int g = 0; g < 4; g++) acc[g] = 0;
    @(negedge clk);
    t_valid = 1'b1; t_we = 1'b0; t_addr = 32'h10; t_size = 2'd2; t_uns = 1'b0;
    for (int c = 0; c < 20; c++) begin
      for (int g = 0; g < 4; g++) begin
        if (rdy_v[g]) acc[g]++;
        if (vld_v[g]) chk($sformatf("held_load_rdata L%0d", g + 1), u_rdata[g], ref_load(32'h10, 2'd2, 1'b0));
      end
      @(negedge clk);
    end
    t_valid = 1'b0;
    for (int g = 0; g < 4; g++) chk($sformatf("accept_count L%0d", g + 1), 32'(acc[g]), 32'((20 + g + 1) / (g + 2)));
    repeat (6) @(negedge clk);

    // Reset one cycle after a load accept: response is dropped, memory kept.
    t_valid = 1'b1; t_we = 1'b0; t_addr = 32'h10; t_size = 2'd2; t_uns = 1'b0;
    @(posedge clk);
    #1 t_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_valid", {28'h0, vld_v}, 32'h0);
    chk("reset_mid_outputs", {28'h0, busy_out_v}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_valid@%0d", k), {28'h0, vld_v}, 32'h0);
      chk($sformatf("post_reset_ready@%0d", k), {28'h0, rdy_v}, 32'hF);
    end
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    chk("post_reset_readback", obs_rdata[2], ref_load(32'h10, 2'd2, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
